mcntrl_chn_arbiter: RTL and testbench
=====================================

MCNTRL_CHN_ARBITER -- requirements
Module: mcntrl_chn_arbiter

Interface
REQ-001 Parameter CHANNELS, default 4, sets the number of requesting channels (legal range 2..16).
REQ-002 Parameter TIMEOUT_BITS, default 4, sets the width of the grant-watchdog counter (used only with MCNTRL_ARB_TIMEOUT_EN).
REQ-003 Ports SHALL be as follows (clock and reset first):
- mclk  input  1  system memory clock; all logic on its posedge.
- rst  input  1  asynchronous, active-high reset.
- want_rq  input  CHANNELS  per-channel request for sequencer access.
- need_rq  input  CHANNELS  per-channel urgent request; valid only together with want_rq.
- ready  input  1  sequencer idle and able to accept a program; the sequencer drops it in the same cycle it samples seq_set.
- seq_set  input  1  OR of all channels' seq_set; the granted channel has loaded its sequence address.
- channel_pgm_en  output  CHANNELS  one-hot, single-cycle grant pulse (registered).
- grant_chn  output  4  number of the last granted channel.
- busy  output  1  arbiter is not in IDLE.
- timeout  output  1  sticky watchdog flag; constant 0 when the watchdog is compiled out.

Function
REQ-004 The block SHALL implement the FSM states IDLE, GRANT and WAIT_SET.
REQ-005 A channel is eligible when its want_rq bit is 1.
REQ-006 An eligible channel is in the urgent class when both want_rq and need_rq are 1; need_rq without want_rq SHALL be ignored.
REQ-007 In IDLE with ready=1 and any eligible channel, the arbiter SHALL select the winner and move to GRANT on the next posedge.
- If any channel is urgent, the winner is the first urgent channel.
- Otherwise the winner is the first eligible channel.
- "First" means round-robin order, starting at (grant_chn+1) mod CHANNELS and wrapping past CHANNELS-1 to 0.
REQ-008 In GRANT, channel_pgm_en[winner] SHALL be 1 for exactly one cycle, and grant_chn SHALL be updated to the winner in that same cycle.
- Latency: request sampled in cycle N → pulse in cycle N+1.
- The next state is WAIT_SET.
REQ-009 In WAIT_SET, seq_set=1 SHALL return the FSM to IDLE.
- The requester dropping want_rq during WAIT_SET SHALL NOT abort the wait.
REQ-010 No grant SHALL occur while ready=0.
- Requests SHALL be held off; no request is latched or queued.
REQ-011 A seq_set arriving in IDLE or GRANT SHALL be ignored.
REQ-012 busy SHALL be 1 in the GRANT and WAIT_SET states.
REQ-013 At most one channel_pgm_en bit SHALL be 1 in any cycle.
REQ-014 The winner SHALL be held in a registered index; grant_chn SHALL be zero-extended to 4 bits.

Reset
REQ-015 rst SHALL asynchronously force:
- state IDLE;
- channel_pgm_en = 0;
- grant_chn = CHANNELS-1, so the first round-robin search starts at channel 0;
- busy = 0;
- timeout = 0;
- the watchdog counter = 0.
REQ-016 rst asserted mid-GRANT SHALL suppress the grant pulse in that cycle.
REQ-017 After rst deasserts, the first grant SHALL occur no earlier than the second posedge.

Configuration
REQ-018 The watchdog SHALL be compiled in only when macro MCNTRL_ARB_TIMEOUT_EN is defined.
REQ-019 With MCNTRL_ARB_TIMEOUT_EN defined:
- The watchdog counter clears on entry to WAIT_SET and increments each cycle spent in WAIT_SET.
- When the counter reaches 2^TIMEOUT_BITS-1 without seq_set, the FSM SHALL return to IDLE and set timeout=1.
- timeout stays set until rst.
- If seq_set and terminal count occur in the same cycle, the result counts as a normal completion (timeout not set).
REQ-020 Without MCNTRL_ARB_TIMEOUT_EN:
- WAIT_SET waits indefinitely for seq_set.
- timeout is tied to 0 and no counter logic exists.

Verification
REQ-021 Single request: CHANNELS=4, ready=1, want_rq=0010 in cycle N → channel_pgm_en=0010 in cycle N+1 only, and grant_chn=1; seq_set in N+2 → busy=0 in N+3.
REQ-022 Round-robin: want_rq=1111 held, need_rq=0, ready=1, seq_set two cycles after each pulse → grant order 0,1,2,3,0.
REQ-023 Priority: grant_chn=0, want_rq=1110, need_rq=1000 → channel 3 is granted first; with need_rq removed, channel 1 is granted next.
REQ-024 Back-pressure: ready=0 with want_rq=0001 for 10 cycles → no pulse; ready rising in cycle M → pulse in cycle M+1.
REQ-025 Watchdog (MCNTRL_ARB_TIMEOUT_EN defined, TIMEOUT_BITS=4): grant issued with no seq_set → return to IDLE 15 cycles after entering WAIT_SET, timeout=1, and the next request is granted normally. Without the macro: busy stays 1 indefinitely.
REQ-026 Reset mid-operation: rst pulsed during WAIT_SET → all outputs at reset values immediately; grant_chn=3; the next grant goes to the lowest-numbered requester.

Source files
------------

// File: rtl/mcntrl_chn_arbiter_if.sv
// Request/grant bundle between the memory-controller channels and the
// sequencer arbiter. The master side is the channel/sequencer complex; the
// slave side is the arbiter itself.
interface mcntrl_chn_arbiter_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] want_rq;
    logic [CHANNELS-1:0] need_rq;
    logic                ready;
    logic                seq_set;
    logic [CHANNELS-1:0] channel_pgm_en;
    logic [3:0]          grant_chn;
    logic                busy;
    logic                timeout;

    modport master (
        output want_rq, need_rq, ready, seq_set,
        input  channel_pgm_en, grant_chn, busy, timeout
    );

    modport slave (
        input  want_rq, need_rq, ready, seq_set,
        output channel_pgm_en, grant_chn, busy, timeout
    );
endinterface

// File: rtl/mcntrl_chn_arbiter.sv
// Round-robin arbiter granting one memory channel at a time access to the
// sequencer. Urgent requests (need_rq with want_rq) take precedence over
// plain ones; within a class the search starts just after the last winner.
// Optional grant watchdog: define MCNTRL_ARB_TIMEOUT_EN to compile it in.
module mcntrl_chn_arbiter #(
    parameter int CHANNELS     = 4,
    parameter int TIMEOUT_BITS = 4
) (
    input  logic mclk,
    input  logic rst,
    mcntrl_chn_arbiter_if.slave arb
);
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST_CHN = IDX_W'(CHANNELS - 1);

    if (CHANNELS < 2 || CHANNELS > 16) begin : g_bad_channels
        $error("CHANNELS must be in 2..16");
    end
    if (TIMEOUT_BITS < 2) begin : g_bad_timeout
        $error("TIMEOUT_BITS must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, GRANT, WAIT_SET} state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    grant_idx;
    logic [CHANNELS-1:0] pgm_en_r;
    logic                arb_en;     // low for the first cycle after reset
    logic                take;       // winner is latched on this edge
    logic                wd_term;    // watchdog expiry in WAIT_SET

    logic [CHANNELS-1:0] urgent;
    logic [CHANNELS-1:0] pick_vec;
    logic [IDX_W-1:0]    rr_start;
    logic [IDX_W:0]      cand;
    logic                win_found;
    logic [IDX_W-1:0]    win_idx;

    assign rr_start = (grant_idx == LAST_CHN) ? '0 : grant_idx + 1'b1;

    // Pick the first requester in round-robin order from the highest active class.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        urgent    = arb.want_rq & arb.need_rq;
        pick_vec  = (|urgent) ? urgent : arb.want_rq;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = rr_start;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = {1'b0, rr_start} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(CHANNELS)) begin
                cand = cand - (IDX_W+1)'(CHANNELS);
            end
            if (!win_found && pick_vec[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Next-state decode: grant only from IDLE when the sequencer is ready.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (arb_en && arb.ready && win_found) begin
                    take      = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT:    state_nxt = WAIT_SET;
            WAIT_SET: if (arb.seq_set || wd_term) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge mclk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Winner index, one-cycle grant pulse and post-reset enable.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            grant_idx <= LAST_CHN;
            pgm_en_r  <= '0;
            arb_en    <= 1'b0;
        end else begin
            arb_en   <= 1'b1;
            pgm_en_r <= '0;
            if (take) begin
                grant_idx          <= win_idx;
                pgm_en_r[win_idx]  <= 1'b1;
            end
        end
    end

`ifdef MCNTRL_ARB_TIMEOUT_EN
    // Expiry fires on the edge where the counter would reach all-ones.
    localparam logic [TIMEOUT_BITS-1:0] WD_LAST = TIMEOUT_BITS'((2 ** TIMEOUT_BITS) - 2);

    logic [TIMEOUT_BITS-1:0] wd_cnt;
    logic                    timeout_r;

    // A seq_set in the terminal cycle wins, so it completes normally.
    assign wd_term = (state == WAIT_SET) && (wd_cnt == WD_LAST) && !arb.seq_set;

    // Watchdog counter cleared on the way into WAIT_SET; sticky timeout flag.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            wd_cnt    <= '0;
            timeout_r <= 1'b0;
        end else begin
            if (state == GRANT)         wd_cnt <= '0;
            else if (state == WAIT_SET) wd_cnt <= wd_cnt + 1'b1;
            if (wd_term)                timeout_r <= 1'b1;
        end
    end

    assign arb.timeout = timeout_r;
`else
    assign wd_term     = 1'b0;
    assign arb.timeout = 1'b0;
`endif

    assign arb.channel_pgm_en = pgm_en_r;
    assign arb.grant_chn      = 4'(grant_idx);
    assign arb.busy           = (state != IDLE);
endmodule

// File: tb/tb_mcntrl_chn_arbiter.sv
// Self-checking bench for mcntrl_chn_arbiter (CHANNELS=4, TIMEOUT_BITS=4).
// Expected grants go into a scoreboard queue when requests are driven; a
// monitor pops and compares them whenever a grant pulse appears.
module tb_mcntrl_chn_arbiter;
    localparam int CH = 4;

    logic mclk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   exp_q[$];

    mcntrl_chn_arbiter_if #(.CHANNELS(CH)) arb_if ();

    mcntrl_chn_arbiter #(.CHANNELS(CH), .TIMEOUT_BITS(4)) dut (
        .mclk (mclk),
        .rst  (rst),
        .arb  (arb_if)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    typedef struct {
        logic [CH-1:0] want;
        logic [CH-1:0] need;
        int            exp_ch;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every grant pulse must match the oldest expectation.
    always @(negedge mclk) begin
        if (!rst && (|arb_if.channel_pgm_en)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_grant", int'(arb_if.channel_pgm_en), 0);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("grant_onehot", int'(arb_if.channel_pgm_en), 1 << e);
                check("grant_chn", int'(arb_if.grant_chn), e);
            end
        end
    end

    // One full transaction: request for one cycle, seq_set two cycles later.
    task automatic do_txn(input logic [CH-1:0] want, input logic [CH-1:0] need, input int exp_ch);
        arb_if.want_rq = want;
        arb_if.need_rq = need;
        arb_if.ready   = 1'b1;
        exp_q.push_back(exp_ch);
        @(posedge mclk); #1;
        check("busy_in_grant", int'(arb_if.busy), 1);
        arb_if.want_rq = '0;
        arb_if.need_rq = '0;
        @(posedge mclk); #1;
        arb_if.seq_set = 1'b1;
        arb_if.ready   = 1'b0;
        @(posedge mclk); #1;
        arb_if.seq_set = 1'b0;
        arb_if.ready   = 1'b1;
        check("idle_after_set", int'(arb_if.busy), 0);
        check("grant_seen", exp_q.size(), 0);
    endtask

    initial begin
        int fall;
        int got;
        int since;

        vecs[0]  = '{4'b0010, 4'b0000, 1};
        vecs[1]  = '{4'b1111, 4'b0000, 2};
        vecs[2]  = '{4'b1111, 4'b0000, 3};
        vecs[3]  = '{4'b1111, 4'b0000, 0};
        vecs[4]  = '{4'b0001, 4'b0000, 0};
        vecs[5]  = '{4'b1110, 4'b1000, 3};
        vecs[6]  = '{4'b1110, 4'b0000, 1};
        vecs[7]  = '{4'b0101, 4'b0010, 2};
        vecs[8]  = '{4'b1011, 4'b0011, 0};
        vecs[9]  = '{4'b1001, 4'b0001, 0};
        vecs[10] = '{4'b1000, 4'b0000, 3};
        vecs[11] = '{4'b0100, 4'b0100, 2};

        rst            = 1'b1;
        arb_if.want_rq = '0;
        arb_if.need_rq = '0;
        arb_if.ready   = 1'b0;
        arb_if.seq_set = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        check("rst_busy", int'(arb_if.busy), 0);
        check("rst_pgm_en", int'(arb_if.channel_pgm_en), 0);
        check("rst_grant_chn", int'(arb_if.grant_chn), 3);
        check("rst_timeout", int'(arb_if.timeout), 0);
        rst = 1'b0;
        @(posedge mclk); #1;

        // Table-driven arbitration vectors.
        foreach (vecs[i]) do_txn(vecs[i].want, vecs[i].need, vecs[i].exp_ch);

        // Back-pressure: no grant while ready is low, grant the cycle after it rises.
        arb_if.ready   = 1'b0;
        arb_if.want_rq = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            @(posedge mclk); #1;
            check("hold_off", int'(arb_if.channel_pgm_en), 0);
        end
        do_txn(4'b0001, 4'b0000, 0);

        // seq_set in IDLE or GRANT must not end the wait.
        arb_if.seq_set = 1'b1;
        @(posedge mclk); #1;
        arb_if.seq_set = 1'b0;
        check("set_in_idle", int'(arb_if.busy), 0);
        arb_if.want_rq = 4'b1000;
        exp_q.push_back(3);
        @(posedge mclk); #1;
        arb_if.want_rq = '0;
        arb_if.seq_set = 1'b1;
        @(posedge mclk); #1;
        arb_if.seq_set = 1'b0;
        @(posedge mclk); #1;
        check("set_in_grant_ignored", int'(arb_if.busy), 1);
        arb_if.seq_set = 1'b1;
        @(posedge mclk); #1;
        arb_if.seq_set = 1'b0;
        check("set_in_wait_done", int'(arb_if.busy), 0);

        // Grant with no seq_set: watchdog expiry or indefinite wait.
        arb_if.want_rq = 4'b0010;
        exp_q.push_back(1);
        @(posedge mclk); #1;
        arb_if.want_rq = '0;
        fall = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge mclk); #1;
            if (!arb_if.busy && fall == 0) fall = k;
        end
`ifdef MCNTRL_ARB_TIMEOUT_EN
        check("wd_idle_cycle", fall, 16);
        check("wd_timeout_set", int'(arb_if.timeout), 1);
`else
        check("no_wd_busy_held", fall, 0);
        check("no_wd_timeout", int'(arb_if.timeout), 0);
        arb_if.seq_set = 1'b1;
        @(posedge mclk); #1;
        arb_if.seq_set = 1'b0;
        check("no_wd_set_done", int'(arb_if.busy), 0);
`endif
        do_txn(4'b0100, 4'b0000, 2);

        // Reset during WAIT_SET, then round-robin with all channels held.
        arb_if.want_rq = 4'b1000;
        exp_q.push_back(3);
        @(posedge mclk); #1;
        arb_if.want_rq = '0;
        @(posedge mclk); #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(arb_if.busy), 0);
        check("midrst_pgm_en", int'(arb_if.channel_pgm_en), 0);
        check("midrst_grant_chn", int'(arb_if.grant_chn), 3);
        check("midrst_timeout", int'(arb_if.timeout), 0);
        arb_if.want_rq = 4'b1111;
        arb_if.ready   = 1'b1;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        @(posedge mclk); #1;
        rst = 1'b0;
        @(posedge mclk); #1;
        check("first_edge_no_grant", int'(arb_if.channel_pgm_en), 0);
        got   = 0;
        since = -1;
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(posedge mclk); #1;
            arb_if.seq_set = 1'b0;
            if (|arb_if.channel_pgm_en) begin
                got++;
                since = 0;
            end else if (since >= 0) begin
                since++;
                if (since == 2) begin
                    arb_if.seq_set = 1'b1;
                    since = -1;
                end
            end
        end
        check("rr_grant_count", got, 5);
        arb_if.want_rq = '0;
        @(posedge mclk); #1;
        arb_if.seq_set = 1'b1;
        @(posedge mclk); #1;
        arb_if.seq_set = 1'b0;
        check("rr_final_idle", int'(arb_if.busy), 0);
        check("scoreboard_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
